// File: rtl/topk_merge_unit.sv
// Top-K list merge unit: loads a new (and optionally an old) sorted list as
// LANES-wide beats, two-pointer merges the first K entries, and streams the result.
module topk_merge_unit #(
  parameter int K     = 20,
  parameter int LANES = 16,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               merge_en,
  input  logic               ascending,
  input  logic               new_valid,
  output logic               new_ready,
  input  logic [LANES*W-1:0] new_beat,
  input  logic               old_valid,
  output logic               old_ready,
  input  logic [LANES*W-1:0] old_beat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_beat,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: a beat moves on any stream only when valid and ready are both
  // high at a rising edge; ready here depends on state alone, never on valid.

  localparam int SLOTS = 2 * K;
  localparam int BEATS = (SLOTS + LANES - 1) / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int PW    = $clog2(K + 1);

  localparam logic [BW-1:0] BEATS_C   = BW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] K_C       = PW'(K);
  localparam logic [PW-1:0] KM1_C     = PW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MERGE = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            merge_q, merge_d;
  logic            asc_q, asc_d;
  logic [BW-1:0]   ncnt_q, ncnt_d;
  logic [BW-1:0]   ocnt_q, ocnt_d;
  logic [BW-1:0]   out_cnt_q, out_cnt_d;
  logic [PW-1:0]   pn_q, pn_d;
  logic [PW-1:0]   po_q, po_d;
  logic [PW-1:0]   m_q, m_d;
  logic            done_q, done_d;

  logic [W-1:0]    new_mem_q [SLOTS];
  logic [W-1:0]    new_mem_d [SLOTS];
  logic [W-1:0]    old_mem_q [SLOTS];
  logic [W-1:0]    old_mem_d [SLOTS];
  logic [W-1:0]    res_mem_q [SLOTS];
  logic [W-1:0]    res_mem_d [SLOTS];

  logic            new_fire, old_fire, take_new;
  logic [W-1:0]    nd, ni, od, oi;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      merge_q   <= 1'b0;
      asc_q     <= 1'b0;
      ncnt_q    <= '0;
      ocnt_q    <= '0;
      out_cnt_q <= '0;
      pn_q      <= '0;
      po_q      <= '0;
      m_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      merge_q   <= merge_d;
      asc_q     <= asc_d;
      ncnt_q    <= ncnt_d;
      ocnt_q    <= ocnt_d;
      out_cnt_q <= out_cnt_d;
      pn_q      <= pn_d;
      po_q      <= po_d;
      m_q       <= m_d;
      done_q    <= done_d;
    end
  end

  // List storage is never reset: nothing reads it before a full LOAD rewrites it.
  always_ff @(posedge clk) begin
    new_mem_q <= new_mem_d;
    old_mem_q <= old_mem_d;
    res_mem_q <= res_mem_d;
  end

  always_comb begin
    nd = '0;
    ni = '0;
    od = '0;
    oi = '0;
    for (int s = 0; s < K; s++) begin
      if (int'(pn_q) == s) begin
        nd = new_mem_q[s];
        ni = new_mem_q[K + s];
      end
      if (int'(po_q) == s) begin
        od = old_mem_q[s];
        oi = old_mem_q[K + s];
      end
    end
    // Ties fall to the old list so earlier results keep their position.
    if (!merge_q || po_q == K_C) begin
      take_new = 1'b1;
    end else if (pn_q == K_C) begin
      take_new = 1'b0;
    end else begin
      take_new = asc_q ? (nd < od) : (nd > od);
    end
  end

  always_comb begin
    state_d   = state_q;
    merge_d   = merge_q;
    asc_d     = asc_q;
    ncnt_d    = ncnt_q;
    ocnt_d    = ocnt_q;
    out_cnt_d = out_cnt_q;
    pn_d      = pn_q;
    po_d      = po_q;
    m_d       = m_q;
    done_d    = 1'b0;
    new_mem_d = new_mem_q;
    old_mem_d = old_mem_q;
    res_mem_d = res_mem_q;
    new_fire  = new_valid && new_ready;
    old_fire  = old_valid && old_ready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          merge_d = merge_en;
          asc_d   = ascending;
          ncnt_d  = '0;
          ocnt_d  = '0;
        end
      end
      S_LOAD: begin
        for (int s = 0; s < SLOTS; s++) begin
          if (new_fire && (s / LANES) == int'(ncnt_q)) begin
            new_mem_d[s] = new_beat[(s % LANES) * W +: W];
          end
          if (old_fire && (s / LANES) == int'(ocnt_q)) begin
            old_mem_d[s] = old_beat[(s % LANES) * W +: W];
          end
        end
        if (new_fire) begin
          ncnt_d = ncnt_q + BW'(1);
        end
        if (old_fire) begin
          ocnt_d = ocnt_q + BW'(1);
        end
        if (ncnt_q == BEATS_C && (!merge_q || ocnt_q == BEATS_C)) begin
          state_d = S_MERGE;
          pn_d    = '0;
          po_d    = '0;
          m_d     = '0;
        end
      end
      S_MERGE: begin
        for (int s = 0; s < K; s++) begin
          if (int'(m_q) == s) begin
            res_mem_d[s]     = take_new ? nd : od;
            res_mem_d[K + s] = take_new ? ni : oi;
          end
        end
        if (take_new) begin
          pn_d = pn_q + PW'(1);
        end else begin
          po_d = po_q + PW'(1);
        end
        if (m_q == KM1_C) begin
          state_d   = S_EMIT;
          out_cnt_d = '0;
        end else begin
          m_d = m_q + PW'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (out_cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    new_ready = (state_q == S_LOAD) && (ncnt_q != BEATS_C);
    old_ready = (state_q == S_LOAD) && merge_q && (ocnt_q != BEATS_C);
    out_valid = (state_q == S_EMIT);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    dbg_state = state_q;
    out_beat  = '0;
    if (state_q == S_EMIT) begin
      for (int s = 0; s < SLOTS; s++) begin
        if ((s / LANES) == int'(out_cnt_q)) begin
          out_beat[(s % LANES) * W +: W] = res_mem_q[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_topk_merge_unit.sv
// Self-checking bench for topk_merge_unit: directed pass/merge/tie/backpressure/
// reset jobs plus a few random sorted-list jobs, checked against a merge model.
module tb_topk_merge_unit;

  localparam int K       = 20;
  localparam int LANES   = 16;
  localparam int W       = 32;
  localparam int SLOTS   = 2 * K;
  localparam int BEATS   = (SLOTS + LANES - 1) / LANES;
  localparam int BWID    = LANES * W;
  localparam int LAT_MAX = 200;
  localparam int EMT_MAX = 50;

  logic            clk;
  logic            rst;
  logic            start, merge_en, ascending;
  logic            new_valid, new_ready, old_valid, old_ready;
  logic [BWID-1:0] new_beat, old_beat, out_beat;
  logic            out_valid, out_ready, busy, done;
  logic [1:0]      dbg_state;

  logic [W-1:0]    nl  [SLOTS];
  logic [W-1:0]    ol  [SLOTS];
  logic [W-1:0]    res [SLOTS];
  logic [BWID-1:0] exp_q [$];

  int n_tests;
  int n_fail;

  topk_merge_unit #(.K(K), .LANES(LANES), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .merge_en(merge_en), .ascending(ascending),
    .new_valid(new_valid), .new_ready(new_ready), .new_beat(new_beat),
    .old_valid(old_valid), .old_ready(old_ready), .old_beat(old_beat),
    .out_valid(out_valid), .out_ready(out_ready), .out_beat(out_beat),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BWID-1:0] got, input logic [BWID-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BWID-1:0] pack(input int sel, input int b);
    logic [BWID-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      int s;
      s = b * LANES + l;
      if (s < SLOTS) begin
        v[l*W +: W] = (sel == 0) ? nl[s] : (sel == 1) ? ol[s] : res[s];
      end
    end
    return v;
  endfunction

  task automatic build_expected(input bit merge, input bit asc);
    int  pn, po;
    bit  tn;
    pn = 0;
    po = 0;
    for (int m = 0; m < K; m++) begin
      if (!merge)        tn = 1'b1;
      else if (po >= K)  tn = 1'b1;
      else if (pn >= K)  tn = 1'b0;
      else               tn = asc ? (nl[pn] < ol[po]) : (nl[pn] > ol[po]);
      if (tn) begin
        res[m] = nl[pn]; res[K+m] = nl[K+pn]; pn++;
      end else begin
        res[m] = ol[po]; res[K+m] = ol[K+po]; po++;
      end
    end
    for (int b = 0; b < BEATS; b++) exp_q.push_back(pack(2, b));
  endtask

  task automatic rand_lists(input bit asc);
    int vn, vo;
    vn = asc ? $urandom_range(0, 5) : 200 + $urandom_range(0, 5);
    vo = asc ? $urandom_range(0, 5) : 200 + $urandom_range(0, 5);
    for (int i = 0; i < K; i++) begin
      nl[i] = W'(vn); ol[i] = W'(vo);
      nl[K+i] = $urandom; ol[K+i] = $urandom;
      if (asc) begin
        vn += $urandom_range(0, 3); vo += $urandom_range(0, 3);
      end else begin
        vn -= $urandom_range(0, 3); vo -= $urandom_range(0, 3);
      end
    end
  endtask

  task automatic run_job(input bit merge, input bit asc, input bit gaps, input bit bp,
                         input int rst_at, input bit poke, input bit chain);
    int nb, ob, lat, mcyc, nout, cyc;
    bit fn, fo, bad_rdy, stalled;
    logic [BWID-1:0] held, e;
    if (rst_at < 0) build_expected(merge, asc);
    start = 1'b1; merge_en = merge; ascending = asc;
    @(posedge clk); #1;
    start = 1'b0; merge_en = ~merge; ascending = ~asc;
    nb = 0; ob = 0; lat = 0; mcyc = 0; bad_rdy = 1'b0;
    while (!out_valid && lat < LAT_MAX) begin
      start     = poke && (lat == 1);
      new_valid = (nb < BEATS);
      new_beat  = pack(0, (nb < BEATS) ? nb : 0);
      old_valid = (ob < BEATS) && !(gaps && $urandom_range(0, 1) == 1);
      old_beat  = pack(1, (ob < BEATS) ? ob : 0);
      if (dbg_state == 2'd2) begin
        mcyc++;
        if (new_ready || old_ready || out_valid) bad_rdy = 1'b1;
        if (mcyc == rst_at) begin
          rst = 1'b0;
          @(posedge clk); #1;
          rst = 1'b1; new_valid = 1'b0; old_valid = 1'b0;
          check("rst_state", dbg_state, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_out_valid", out_valid, 0);
          check("rst_rdy", {new_ready, old_ready}, 0);
          check("rst_out_beat", out_beat, 0);
          repeat (5) @(posedge clk);
          #1;
          check("abort_no_emit", {out_valid, busy}, 0);
          return;
        end
      end
      fn = new_valid && new_ready;
      fo = old_valid && old_ready;
      @(posedge clk); #1;
      lat++;
      if (fn) nb++;
      if (fo) ob++;
    end
    start = 1'b0; new_valid = 1'b0; old_valid = 1'b0;
    check("out_valid_seen", out_valid, 1);
    if (!gaps) check("latency", lat, 1 + BEATS + K);
    check("new_beats", nb, BEATS);
    check("old_beats", ob, merge ? BEATS : 0);
    check("merge_rdy_low", bad_rdy, 0);
    nout = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (nout < BEATS && cyc < EMT_MAX) begin
      out_ready = bp ? (cyc % 2 == 1) : 1'b1;
      if (stalled) check("stall_stable", out_beat, held);
      if (!out_valid) begin
        check("emit_valid", out_valid, 1);
        break;
      end
      if (out_ready) begin
        e = exp_q.pop_front();
        check($sformatf("beat%0d", nout), out_beat, e);
        if (nout == BEATS - 1) check("pad_zero", out_beat[BWID-1:256], 0);
        stalled = 1'b0;
        nout++;
      end else begin
        held = out_beat;
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("beats_out", nout, BEATS);
    check("done_pulse", {done, busy}, 2'b10);
    if (!chain) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; merge_en = 1'b0; ascending = 1'b0;
    new_valid = 1'b0; old_valid = 1'b0; out_ready = 1'b0;
    new_beat = '0; old_beat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dbg_state, 0);
    check("reset_flags", {busy, done, out_valid, new_ready, old_ready}, 0);
    check("reset_out_beat", out_beat, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pass mode: result equals the new list; old list is garbage and must be ignored.
    for (int i = 0; i < K; i++) begin
      nl[i] = W'(i); nl[K+i] = W'(100 + i);
      ol[i] = $urandom; ol[K+i] = $urandom;
    end
    run_job(1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Ascending merge of evens and odds.
    for (int i = 0; i < K; i++) begin
      nl[i] = W'(2 * i);     nl[K+i] = W'(200 + i);
      ol[i] = W'(2 * i + 1); ol[K+i] = W'(300 + i);
    end
    run_job(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    check("merge_asc_data0", res[19], 19);
    check("merge_asc_idx1", res[K+1], 300);

    // Descending with all ties: every entry must come from the old list.
    for (int i = 0; i < K; i++) begin
      nl[i] = 5; nl[K+i] = W'(i);
      ol[i] = 5; ol[K+i] = W'(50 + i);
    end
    run_job(1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Same payload as the ascending merge, with old_valid gaps and output stalls.
    for (int i = 0; i < K; i++) begin
      nl[i] = W'(2 * i);     nl[K+i] = W'(200 + i);
      ol[i] = W'(2 * i + 1); ol[K+i] = W'(300 + i);
    end
    run_job(1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0);

    // Reset in MERGE cycle 7, then a complete job.
    run_job(1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b0);
    rand_lists(1'b1);
    run_job(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Random jobs; the first two are chained so start lands in the done cycle.
    for (int j = 0; j < 4; j++) begin
      bit asc, mrg;
      asc = $urandom_range(0, 1);
      mrg = (j == 3) ? 1'b0 : 1'b1;
      rand_lists(asc);
      run_job(mrg, asc, $urandom_range(0, 1), $urandom_range(0, 1), -1, 1'b0, (j < 2));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/topk_merge_unit.md
TOPK_MERGE_UNIT -- requirements
Module: topk_merge_unit

Interface
REQ-001 Parameter K, default 20, list length (entries kept), legal range 1..64.
REQ-002 Parameter LANES, default 16, 32-bit words per stream beat.
REQ-003 Parameter W, default 32, width of data and index words.
REQ-004 Derived BEATS = ceil(2K/LANES); a list is K data words (slots 0..K-1) then K index words (slots K..2K-1), beat b carries slots b*LANES..b*LANES+LANES-1, lane 0 lowest.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle job request, sampled only in IDLE.
REQ-008 merge_en  input  1  sampled with start: 0 = pass new list, 1 = merge new with old.
REQ-009 ascending  input  1  sampled with start: 1 = smallest first, 0 = largest first.
REQ-010 new_valid/new_ready  input/output  1/1  MLU beat handshake.
REQ-011 new_beat  input  LANES*W  MLU beat payload.
REQ-012 old_valid/old_ready  input/output  1/1  output-buffer beat handshake.
REQ-013 old_beat  input  LANES*W  previously sorted list beat.
REQ-014 out_valid/out_ready  output/input  1/1  result beat handshake.
REQ-015 out_beat  output  LANES*W  result beat payload.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse on acceptance of final result beat.

Function
REQ-018 States IDLE, LOAD, MERGE, EMIT; transfer on any stream occurs only when valid and ready are both high at a rising edge.
REQ-019 IDLE: start=1 latches merge_en/ascending, clears beat counters, goes to LOAD next cycle; start outside IDLE ignored.
REQ-020 LOAD: new_ready=1 until BEATS new beats taken; old_ready=1 until BEATS old beats taken if merge_en=1, else old_ready=0; streams progress independently; ready drops the cycle after each stream's last beat.
REQ-021 LOAD exits to MERGE the cycle after all required beats are received; lanes of the final beat beyond slot 2K-1 are discarded.
REQ-022 MERGE, merge_en=0: result = new list unchanged, one slot per cycle, K cycles.
REQ-023 MERGE, merge_en=1: two-pointer merge of both lists (each assumed pre-sorted in chosen order), one result entry per cycle, K cycles; new entry taken iff (ascending ? new<old : new>old), unsigned compare, ties take old; exhausted list yields other list's next entry; index words travel with their data.
REQ-024 Only first K merged entries are kept; remaining entries are dropped.
REQ-025 EMIT: out_valid=1, presents beats 0..BEATS-1 in order; beat advances only on out_ready=1; out_beat stable while out_valid=1 and out_ready=0; pad slots ≥2K drive zero.
REQ-026 After final beat accepted: done=1 for that next cycle, state returns to IDLE; a start in the same cycle as done is accepted.
REQ-027 new_ready, old_ready, out_valid all 0 in IDLE and MERGE.
REQ-028 Start-to-first out_valid latency, with inputs always valid: 1 + BEATS + K cycles (BEATS+1 in LOAD incl. exit, K in MERGE).

Reset
REQ-029 rst=0 at a rising edge forces IDLE, all counters/pointers 0, busy/done/out_valid/new_ready/old_ready 0, out_beat 0, irrespective of state.
REQ-030 Reset mid-job aborts it; partially loaded beats are discarded and not emitted after release.
REQ-031 Internal list storage need not be cleared; no output depends on it before the next full LOAD.

Verification
REQ-032 Pass mode, K=20, LANES=16: new data 0..19, index 100..119 → 3 out beats equal to input beats; beat 2 lanes 8..15 zero; done one cycle after third acceptance.
REQ-033 Merge ascending: new data evens 0..38, old odds 1..39 → out data 0..19, indices follow source lists.
REQ-034 Merge with ties, descending: all data 5, new idx 0..19, old idx 50..69 → out idx 50..69 (old wins).
REQ-035 Backpressure: out_ready toggled every other cycle, and old_valid gaps during LOAD → payload identical to REQ-033, out_beat stable while stalled.
REQ-036 Reset asserted in MERGE cycle 7 → next cycle all outputs 0, IDLE; following full job produces correct result.
